// File: rtl/md_pkg.sv
// md_unit shared types and constants.
// MD_DIV_EN (define) enables the restoring divider.
package md_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_DONE
  } md_state_e;

  localparam int MD_ITERS = 32;
  localparam int CNT_W = 6;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  function automatic logic [31:0] abs32(
    input logic [31:0] v
  );
    return v[31] ? -v : v;
  endfunction

endpackage

// File: rtl/md_if.sv
// Operand/start/result bundle between the
// X stage and the multiply/divide unit.
interface md_if;

  logic [31:0] data_a;
  logic [31:0] data_b;
  logic        ctrl_mult;
  logic        ctrl_div;
  logic [31:0] result;
  logic        exception;
  logic        ready;
  logic        nops_from_md;

  modport master (
    output data_a, data_b,
    output ctrl_mult, ctrl_div,
    input  result, exception,
    input  ready, nops_from_md
  );

  modport slave (
    input  data_a, data_b,
    input  ctrl_mult, ctrl_div,
    output result, exception,
    output ready, nops_from_md
  );

endinterface

// File: rtl/md_div_step.sv
// One unsigned restoring-division iteration.
// Built only when MD_DIV_EN is defined.
`ifdef MD_DIV_EN
module md_div_step (
  input  logic [31:0] i_rem,
  input  logic [31:0] i_quo,
  input  logic [31:0] i_dvsr,
  output logic [31:0] o_rem,
  output logic [31:0] o_quo
);

  logic [32:0] w_shift;
  logic [32:0] w_diff;

  assign w_shift = {i_rem, i_quo[31]};
  assign w_diff  = w_shift - {1'b0, i_dvsr};

  // w_shift < 2*divisor, so bit 32 is a true borrow
  always_comb begin
    o_rem = w_shift[31:0];
    o_quo = {i_quo[30:0], 1'b0};
    if (!w_diff[32]) begin
      o_rem = w_diff[31:0];
      o_quo = {i_quo[30:0], 1'b1};
    end
  end

endmodule
`endif

// File: rtl/md_unit.sv
// Iterative signed multiply/divide unit.
// Divider built only with `define MD_DIV_EN.
module md_unit
  import md_pkg::*;
(
  input logic clock,
  input logic reset,
  md_if.slave bus
);

  md_state_e r_state;
  md_state_e w_next;

  logic [CNT_W-1:0] r_cnt;
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [31:0] r_mplier;
  logic [31:0] r_result;
  logic        r_exc;

  logic        w_open;
  logic        w_go_mult;
  logic        w_go_div;
  logic        w_last;
  logic        w_div_skip;
  logic        w_ovf;
  logic [63:0] w_pp;
  logic [63:0] w_acc_nxt;
  logic [31:0] w_res_fin;
  logic        w_exc_fin;

  assign w_open = (r_state == S_IDLE) ||
                  (r_state == S_DONE);

  assign w_go_mult = !reset && w_open &&
                     bus.ctrl_mult && !bus.ctrl_div;
  assign w_go_div  = !reset && w_open &&
                     bus.ctrl_div && !bus.ctrl_mult;

  assign w_last =
    (r_cnt == CNT_W'(MD_ITERS - 1));

  // Bit 31 of the multiplier carries weight -2^31
  assign w_pp = r_mplier[0] ? r_mcand : '0;
  assign w_acc_nxt = w_last ? r_acc - w_pp
                            : r_acc + w_pp;
  assign w_ovf = !((&w_acc_nxt[63:31]) ||
                   !(|w_acc_nxt[63:31]));

`ifdef MD_DIV_EN
  logic [31:0] r_rem;
  logic [31:0] r_quo;
  logic [31:0] r_dvsr;
  logic        r_neg;
  logic        r_dovf;
  logic [31:0] w_rem_n;
  logic [31:0] w_quo_n;
  logic [31:0] w_quo_fin;

  md_div_step u_step (
    .i_rem  (r_rem),
    .i_quo  (r_quo),
    .i_dvsr (r_dvsr),
    .o_rem  (w_rem_n),
    .o_quo  (w_quo_n)
  );

  assign w_quo_fin = r_neg ? -w_quo_n : w_quo_n;
  assign w_div_skip = (bus.data_b == '0);
  assign w_res_fin = (r_state == S_DIV) ?
                     w_quo_fin : w_acc_nxt[31:0];
  assign w_exc_fin = (r_state == S_DIV) ?
                     r_dovf : w_ovf;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rem  <= '0;
      r_quo  <= '0;
      r_dvsr <= '0;
      r_neg  <= 1'b0;
      r_dovf <= 1'b0;
    end else if (w_go_div) begin
      r_rem  <= '0;
      r_quo  <= abs32(bus.data_a);
      r_dvsr <= abs32(bus.data_b);
      r_neg  <= bus.data_a[31] ^ bus.data_b[31];
      r_dovf <= (bus.data_a == INT_MIN) &&
                (bus.data_b == '1);
    end else if (r_state == S_DIV) begin
      r_rem <= w_rem_n;
      r_quo <= w_quo_n;
    end
  end
`else
  assign w_div_skip = 1'b1;
  assign w_res_fin  = w_acc_nxt[31:0];
  assign w_exc_fin  = w_ovf;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        w_next = S_IDLE;
        if (w_go_mult)
          w_next = S_MULT;
        else if (w_go_div)
          w_next = w_div_skip ? S_DONE : S_DIV;
      end
      S_MULT, S_DIV: begin
        if (w_last)
          w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (w_go_mult) begin
      r_acc    <= '0;
      r_mcand  <= {{32{bus.data_a[31]}},
                   bus.data_a};
      r_mplier <= bus.data_b;
    end else if (r_state == S_MULT) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt    <= '0;
      r_result <= '0;
      r_exc    <= 1'b0;
    end else if (w_go_mult || w_go_div) begin
      r_cnt <= '0;
      if (w_go_div && w_div_skip) begin
        r_result <= '0;
        r_exc    <= 1'b1;
      end
    end else if (r_state == S_MULT ||
                 r_state == S_DIV) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_result <= w_res_fin;
        r_exc    <= w_exc_fin;
      end
    end
  end

  assign bus.result    = r_result;
  assign bus.exception = r_exc;
  assign bus.ready     = (r_state == S_DONE);
  assign bus.nops_from_md =
    (r_state == S_MULT) || (r_state == S_DIV) ||
    w_go_mult || w_go_div;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed ops
// against a cycle-level arithmetic model.
module tb_md_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_chk = 0;
  int n_fail = 0;

  md_if bus();

  md_unit dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int          m_wait = 0;
  logic [31:0] m_res  = '0;
  logic [31:0] p_res  = '0;
  logic        m_exc  = 1'b0;
  logic        p_exc  = 1'b0;
  logic        m_rdy  = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // Arithmetic meaning of one operation
  function automatic void model(
    input  bit          is_mult,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output int          lat,
    output logic [31:0] r,
    output logic        e
  );
    longint p;
    if (is_mult) begin
      p = longint'($signed(a)) *
          longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(r)));
      lat = 33;
    end else begin
`ifdef MD_DIV_EN
      if (b == 32'h0) begin
        lat = 1; r = '0; e = 1'b1;
      end else if (a == 32'h8000_0000 &&
                   b == 32'hFFFF_FFFF) begin
        lat = 33; r = a; e = 1'b1;
      end else begin
        lat = 33;
        r = $signed(a) / $signed(b);
        e = 1'b0;
      end
`else
      lat = 1; r = '0; e = 1'b1;
`endif
    end
  endfunction

  initial begin : model_p
    int          lat;
    logic [31:0] r;
    logic        e;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_wait = 0;
        m_res = '0;
        m_exc = 1'b0;
        m_rdy = 1'b0;
      end else if (m_wait == 0 &&
                   (bus.ctrl_mult ^ bus.ctrl_div)) begin
        model(bus.ctrl_mult, bus.data_a,
              bus.data_b, lat, r, e);
        m_wait = lat - 1;
        p_res = r;
        p_exc = e;
        m_rdy = (m_wait == 0);
        if (m_rdy) begin
          m_res = r;
          m_exc = e;
        end
      end else if (m_wait > 0) begin
        m_wait--;
        m_rdy = (m_wait == 0);
        if (m_rdy) begin
          m_res = p_res;
          m_exc = p_exc;
        end
      end else begin
        m_rdy = 1'b0;
      end
    end
  end

  initial begin : compare_p
    logic e_nops;
    forever begin
      @(negedge clk);
      e_nops = (m_wait > 0) ||
               (!rst && m_wait == 0 &&
                (bus.ctrl_mult ^ bus.ctrl_div));
      chk("cyc ready", 32'(bus.ready), 32'(m_rdy));
      chk("cyc nops", 32'(bus.nops_from_md),
          32'(e_nops));
      chk("cyc result", bus.result, m_res);
      chk("cyc exc", 32'(bus.exception),
          32'(m_exc));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: no finish by %0t",
             $time);
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drive a start in the current cycle, return in
  // the ready cycle (lat = cycle index, 0 = timeout)
  task automatic run_op(
    input  bit          mul,
    input  bit          dv,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  int          poke,
    output int          lat,
    output logic [31:0] res,
    output logic        e
  );
    bus.ctrl_mult = mul;
    bus.ctrl_div  = dv;
    bus.data_a    = a;
    bus.data_b    = b;
    lat = 0;
    res = '0;
    e   = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      bus.ctrl_mult = 1'b0;
      bus.ctrl_div  = 1'b0;
      if (n == 1) begin
        bus.data_a = $urandom;
        bus.data_b = $urandom;
      end
      if (n == poke) begin
        bus.ctrl_mult = 1'b1;
        bus.data_a = 32'd100;
        bus.data_b = 32'd100;
      end
      if (bus.ready) begin
        lat = n;
        res = bus.result;
        e   = bus.exception;
        break;
      end
    end
  endtask

  task automatic expect_op(
    input string nm,
    input int lat, input logic [31:0] res,
    input logic e,
    input int x_lat, input logic [31:0] x_res,
    input logic x_e
  );
    chk({nm, " lat"}, 32'(lat), 32'(x_lat));
    chk({nm, " res"}, res, x_res);
    chk({nm, " exc"}, 32'(e), 32'(x_e));
  endtask

  initial begin : stim
    int          lat;
    logic [31:0] res;
    logic        e;
    int          seen;
    int          dlat;
    logic [31:0] dres;
    logic        de;

    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    bus.data_a    = '0;
    bus.data_b    = '0;

`ifdef MD_DIV_EN
    dlat = 33; dres = 32'hFFFF_FFFD; de = 1'b0;
`else
    dlat = 1;  dres = 32'h0;         de = 1'b1;
`endif

    // Pin the model to hand-worked answers
    model(1'b1, 32'd7, 32'hFFFF_FFFA, lat, res, e);
    expect_op("model 7*-6", lat, res, e,
              33, 32'hFFFF_FFD6, 1'b0);
    model(1'b1, 32'h0001_0000, 32'h0001_0000,
          lat, res, e);
    expect_op("model ovf", lat, res, e,
              33, 32'h0, 1'b1);
    model(1'b0, 32'hFFFF_FFF9, 32'd2, lat, res, e);
    expect_op("model -7/2", lat, res, e,
              dlat, dres, de);

    repeat (3) @(posedge clk);
    #1;
    chk("reset result", bus.result, 32'h0);
    chk("reset exc", 32'(bus.exception), 32'h0);
    chk("reset ready", 32'(bus.ready), 32'h0);
    chk("reset nops", 32'(bus.nops_from_md), 32'h0);
    rst = 1'b0;

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 0,
           lat, res, e);
    expect_op("mul 7*-6", lat, res, e,
              33, 32'hFFFF_FFD6, 1'b0);
    idle(2);

    run_op(1'b1, 1'b0, 32'h0001_0000,
           32'h0001_0000, 0, lat, res, e);
    expect_op("mul ovf", lat, res, e,
              33, 32'h0, 1'b1);

    // Started in the DONE cycle
    run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0,
           lat, res, e);
    expect_op("div -7/2", lat, res, e,
              dlat, dres, de);
    idle(1);

    run_op(1'b0, 1'b1, 32'd5, 32'd0, 0,
           lat, res, e);
    expect_op("div 5/0", lat, res, e,
              1, 32'h0, 1'b1);

    run_op(1'b1, 1'b0, 32'hFFFF_FFFD, 32'd5, 0,
           lat, res, e);
    expect_op("mul -3*5", lat, res, e,
              33, 32'hFFFF_FFF1, 1'b0);
    idle(1);

    run_op(1'b0, 1'b1, 32'h8000_0000,
           32'hFFFF_FFFF, 0, lat, res, e);
`ifdef MD_DIV_EN
    expect_op("div min/-1", lat, res, e,
              33, 32'h8000_0000, 1'b1);
`else
    expect_op("div min/-1", lat, res, e,
              1, 32'h0, 1'b1);
`endif
    idle(1);

    bus.ctrl_mult = 1'b1;
    bus.ctrl_div  = 1'b1;
    bus.data_a    = 32'd9;
    bus.data_b    = 32'd9;
    @(negedge clk);
    chk("both nops", 32'(bus.nops_from_md), 32'h0);
    @(posedge clk);
    #1;
    bus.ctrl_mult = 1'b0;
    bus.ctrl_div  = 1'b0;
    chk("both nops+1", 32'(bus.nops_from_md),
        32'h0);
    chk("both ready", 32'(bus.ready), 32'h0);

    run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 5,
           lat, res, e);
    expect_op("mul poke", lat, res, e,
              33, 32'hFFFF_FFD6, 1'b0);
    idle(1);

    // Reset in cycle 10 of a multiply
    bus.ctrl_mult = 1'b1;
    bus.data_a = 32'd5;
    bus.data_b = 32'd5;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      bus.ctrl_mult = 1'b0;
      if (c == 10) rst = 1'b1;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort result", bus.result, 32'h0);
    chk("abort exc", 32'(bus.exception), 32'h0);
    chk("abort ready", 32'(bus.ready), 32'h0);
    chk("abort nops", 32'(bus.nops_from_md), 32'h0);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (bus.ready) seen++;
    end
    chk("abort no ready", 32'(seen), 32'h0);

    // Reset wins over a start in the same cycle
    rst = 1'b1;
    bus.ctrl_mult = 1'b1;
    bus.data_a = 32'd2;
    bus.data_b = 32'd2;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.ctrl_mult = 1'b0;
    chk("rst+start nops", 32'(bus.nops_from_md),
        32'h0);
    idle(2);
    chk("rst+start ready", 32'(bus.ready), 32'h0);

    run_op(1'b1, 1'b0, 32'd3, 32'd4, 0,
           lat, res, e);
    expect_op("mul 3*4", lat, res, e,
              33, 32'd12, 1'b0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
